// File: rtl/uart_pkg.sv
// uart_pkg: receiver state type, stop level and parity helper shared with the UART transmitter.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;
  localparam logic UART_STOP_LEVEL = 1'b1;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } uart_rx_state_e;
  // Callers zero-extend their word; leading zeros do not change even parity.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: raw serial line into the receiver, received word and status pulses out to the host.
interface uart_rx_if #(parameter int DATA_BITS = 8);
  logic                 i_rx;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_frame_err;
  logic                 o_parity_err;
  logic                 o_busy;
  modport master (input i_rx, output o_data, o_valid, o_frame_err, o_parity_err, o_busy);
  modport slave (output i_rx, input o_data, o_valid, o_frame_err, o_parity_err, o_busy);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous bit, with a parameterised reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);
  logic meta_q, sync_q;
  always_ff @(posedge i_clk)
    if (i_reset) {sync_q, meta_q} <= {RESET_VAL, RESET_VAL};
    else {sync_q, meta_q} <= {meta_q, i_d};
  assign o_q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver sampling each bit at mid-bit, with one-cycle valid/error pulses.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_rx import uart_pkg::*; #(
  parameter int BAUD_DIV  = 3,
  parameter int DATA_BITS = 8
) (
  input logic       i_clk,
  input logic       i_reset,
  uart_rx_if.master bus
);
  localparam int HALF = BAUD_DIV / 2;
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int BW = $clog2(DATA_BITS + 2);
  localparam logic [CW-1:0] TICK = CW'(BAUD_DIV);
  // Preloading here makes the first tick land HALF cycles after the start edge.
  localparam logic [CW-1:0] FIRST = CW'(BAUD_DIV - HALF + 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam uart_rx_state_e AFTER_DATA = PARITY;
`else
  localparam uart_rx_state_e AFTER_DATA = STOP;
`endif
  generate
    if (BAUD_DIV < 3) begin : g_bad_div
      $error("uart_rx: BAUD_DIV must be >= 3");
    end
  endgenerate
  uart_rx_state_e state_q = IDLE;
  uart_rx_state_e state_d;
  logic rx_s, tick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d;
`ifdef UART_RX_PARITY_EN
  logic pbad_q, pbad_d;
`endif
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (.i_clk(i_clk), .i_reset(i_reset), .i_d(bus.i_rx), .o_q(rx_s));
  assign tick = cnt_q == TICK;
  always_comb begin
    state_d = state_q;
    cnt_d = tick ? CW'(1) : cnt_q + CW'(1);
    bit_d = bit_q;
    sh_d = sh_q;
    data_d = data_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
    perr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d = pbad_q;
`endif
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        cnt_d = FIRST;
      end
      START: if (tick) begin
        state_d = rx_s ? IDLE : DATA;
        bit_d = '0;
      end
      DATA: if (tick) begin
        sh_d = {rx_s, sh_q[DATA_BITS-1:1]};
        bit_d = bit_q + BW'(1);
        state_d = bit_q == LAST ? AFTER_DATA : DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        pbad_d = rx_s != even_parity(64'(sh_q));
        state_d = STOP;
      end
`endif
      STOP: if (tick) begin
        valid_d = rx_s == UART_STOP_LEVEL;
        ferr_d = !valid_d;
        data_d = valid_d ? sh_q : data_q;
`ifdef UART_RX_PARITY_EN
        perr_d = pbad_q;
`endif
        state_d = valid_d ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: state_d = rx_s ? IDLE : WAIT_HIGH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk)
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      perr_q <= perr_d;
`ifdef UART_RX_PARITY_EN
      pbad_q <= pbad_d;
`endif
    end
  assign bus.o_data = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_frame_err = ferr_q;
  assign bus.o_parity_err = perr_q;
  assign bus.o_busy = state_q != IDLE;
endmodule
